// File: rtl/xm_ctrl_pkg.sv
// Shared encodings for the xm sequencing controller: states, instruction classes,
// mux selects and fault codes.
package xm_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH      = 4'd0,
    S_FETCH_WAIT = 4'd1,
    S_DECODE     = 4'd2,
    S_EXEC       = 4'd3,
    S_MEM_WAIT   = 4'd4,
    S_WRITEBACK  = 4'd5,
    S_SWAP_2     = 4'd6,
    S_FAULT      = 4'd7
  } state_e;

  typedef enum logic [3:0] {
    OP_COND_BR = 4'd0,
    OP_LINK_BR = 4'd1,
    OP_ALU     = 4'd2,
    OP_LOAD    = 4'd3,
    OP_STORE   = 4'd4,
    OP_IMM     = 4'd5,
    OP_SWAP    = 4'd6
  } op_e;

  localparam logic [2:0] WSEL_ALU  = 3'd0;
  localparam logic [2:0] WSEL_PC   = 3'd1;
  localparam logic [2:0] WSEL_MEM  = 3'd2;
  localparam logic [2:0] WSEL_IMM  = 3'd3;
  localparam logic [2:0] WSEL_TEMP = 3'd4;

  localparam logic [1:0] ASEL_PC   = 2'd0;
  localparam logic [1:0] ASEL_BASE = 2'd1;
  localparam logic [1:0] ASEL_OFS  = 2'd2;

  localparam logic [1:0] PSEL_INC  = 2'd0;
  localparam logic [1:0] PSEL_BR   = 2'd1;
  localparam logic [1:0] PSEL_FLT  = 2'd2;

  localparam logic [1:0] FC_NONE    = 2'd0;
  localparam logic [1:0] FC_ILLEGAL = 2'd1;
  localparam logic [1:0] FC_TIMEOUT = 2'd2;

  function automatic logic op_legal(input logic [3:0] op);
    return op <= OP_SWAP;
  endfunction

endpackage

// File: rtl/xm_timeout_cnt.sv
// Wait-cycle counter for bus transfers; expired is raised on the TMO_CYC-th
// consecutive enabled cycle after a clear.
module xm_timeout_cnt #(
  parameter int TMO_CYC = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [7:0] cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr)          cnt <= '0;
    else if (en && cnt != 8'hff) cnt <= cnt + 8'd1;
  end

  // cnt holds cycles already spent, so the current cycle is number cnt+1
  assign expired = en && (cnt >= 8'(TMO_CYC - 1));

endmodule

// File: rtl/xm_seq_controller.sv
// Multi-cycle fetch/decode/execute sequencer. Define XM_BUS_TIMEOUT_EN to fault
// on memory acks that do not arrive within TMO_CYC wait cycles.
module xm_seq_controller
  import xm_ctrl_pkg::*;
#(
  parameter int WORD    = 16,
  parameter int LR      = 5,
  parameter int TMO_CYC = 15
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] instOp_i,
  input  logic       branchRes_i,
  input  logic [2:0] regAdrA_i,
  input  logic [2:0] regAdrB_i,
  input  logic       memAck_i,
  input  logic       stall_i,
  output logic       memReq_o,
  output logic       memRW_o,
  output logic [1:0] adrSel_o,
  output logic       pcWr_o,
  output logic       irWr_o,
  output logic       regWr_o,
  output logic       tempWr_o,
  output logic       flagsWr_o,
  output logic [1:0] pcSel_o,
  output logic [2:0] regWrSel_o,
  output logic [2:0] regWrAdr_o,
  output logic       fault_o,
  output logic [1:0] faultCode_o,
  output logic [3:0] state_o
);

  if (WORD < 1) begin : g_word_chk
    $error("xm_seq_controller: WORD must be positive");
  end
  if (TMO_CYC < 1 || TMO_CYC > 255) begin : g_tmo_chk
    $error("xm_seq_controller: TMO_CYC must be 1..255");
  end

  state_e     state, nxt;
  op_e        cls;
  logic [1:0] fault_code, flt_code;
  logic       tmo_exp;

`ifdef XM_BUS_TIMEOUT_EN
  logic in_wait;
  assign in_wait = (state == S_FETCH_WAIT) || (state == S_MEM_WAIT);

  xm_timeout_cnt #(.TMO_CYC(TMO_CYC)) u_tmo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr     (!in_wait),
    .en      (in_wait),
    .expired (tmo_exp)
  );
`else
  assign tmo_exp = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= S_FETCH;
      cls        <= OP_COND_BR;
      fault_code <= FC_NONE;
    end else begin
      state <= nxt;
      if (state == S_DECODE && !stall_i) cls <= op_e'(instOp_i);
      if (nxt == S_FAULT) fault_code <= flt_code;
    end
  end

  always_comb begin
    nxt        = state;
    flt_code   = FC_NONE;
    memReq_o   = 1'b0;
    memRW_o    = 1'b0;
    adrSel_o   = ASEL_PC;
    pcWr_o     = 1'b0;
    irWr_o     = 1'b0;
    regWr_o    = 1'b0;
    tempWr_o   = 1'b0;
    flagsWr_o  = 1'b0;
    pcSel_o    = PSEL_INC;
    regWrSel_o = WSEL_ALU;
    regWrAdr_o = regAdrA_i;
    fault_o    = 1'b0;
    unique case (state)
      S_FETCH: begin
        memReq_o = 1'b1;
        pcWr_o   = 1'b1;
        nxt      = S_FETCH_WAIT;
      end
      S_FETCH_WAIT: begin
        memReq_o = 1'b1;
        if (memAck_i) begin
          irWr_o = 1'b1;
          nxt    = S_DECODE;
        end else if (tmo_exp) begin
          nxt      = S_FAULT;
          flt_code = FC_TIMEOUT;
        end
      end
      S_DECODE: begin
        if (!stall_i) begin
          if (op_legal(instOp_i)) nxt = S_EXEC;
          else begin
            nxt      = S_FAULT;
            flt_code = FC_ILLEGAL;
          end
        end
      end
      S_EXEC: begin
        nxt = S_FETCH;
        case (cls)
          OP_COND_BR: begin
            pcSel_o = PSEL_BR;
            pcWr_o  = branchRes_i;
          end
          OP_LINK_BR: begin
            pcWr_o     = 1'b1;
            pcSel_o    = PSEL_BR;
            regWr_o    = 1'b1;
            regWrSel_o = WSEL_PC;
            regWrAdr_o = 3'(LR);
          end
          OP_ALU: begin
            regWr_o   = 1'b1;
            flagsWr_o = 1'b1;
          end
          OP_IMM: begin
            regWr_o    = 1'b1;
            regWrSel_o = WSEL_IMM;
          end
          OP_SWAP: begin
            tempWr_o = 1'b1;
            regWr_o  = 1'b1;
            nxt      = S_SWAP_2;
          end
          OP_LOAD, OP_STORE: begin
            memReq_o = 1'b1;
            adrSel_o = ASEL_OFS;
            memRW_o  = (cls == OP_STORE);
            nxt      = S_MEM_WAIT;
          end
          default: nxt = S_FETCH;
        endcase
      end
      S_MEM_WAIT: begin
        memReq_o = 1'b1;
        adrSel_o = ASEL_OFS;
        memRW_o  = (cls == OP_STORE);
        if (memAck_i) begin
          nxt = (cls == OP_LOAD) ? S_WRITEBACK : S_FETCH;
        end else if (tmo_exp) begin
          nxt      = S_FAULT;
          flt_code = FC_TIMEOUT;
        end
      end
      S_WRITEBACK: begin
        regWr_o    = 1'b1;
        regWrSel_o = WSEL_MEM;
        regWrAdr_o = regAdrB_i;
        nxt        = S_FETCH;
      end
      S_SWAP_2: begin
        regWr_o    = 1'b1;
        regWrSel_o = WSEL_TEMP;
        regWrAdr_o = regAdrB_i;
        nxt        = S_FETCH;
      end
      S_FAULT: begin
        fault_o    = 1'b1;
        regWr_o    = 1'b1;
        regWrSel_o = WSEL_PC;
        regWrAdr_o = 3'(LR);
        pcWr_o     = 1'b1;
        pcSel_o    = PSEL_FLT;
        nxt        = S_FETCH;
      end
      default: nxt = S_FETCH;
    endcase
  end

  // The latched cause is only visible while the fault pulse is up
  assign faultCode_o = (state == S_FAULT) ? fault_code : FC_NONE;
  assign state_o     = state;

endmodule

// File: tb/tb_xm_seq_controller.sv
// Directed bench for xm_seq_controller; timeout cases run when XM_BUS_TIMEOUT_EN is defined.
module tb_xm_seq_controller;

  localparam int TMO = 4;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [3:0] instOp_i;
  logic       branchRes_i;
  logic [2:0] regAdrA_i, regAdrB_i;
  logic       memAck_i, stall_i;
  logic       memReq_o, memRW_o, pcWr_o, irWr_o, regWr_o, tempWr_o, flagsWr_o, fault_o;
  logic [1:0] adrSel_o, pcSel_o, faultCode_o;
  logic [2:0] regWrSel_o, regWrAdr_o;
  logic [3:0] state_o;

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  xm_seq_controller #(.WORD(16), .LR(5), .TMO_CYC(TMO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .instOp_i(instOp_i), .branchRes_i(branchRes_i),
    .regAdrA_i(regAdrA_i), .regAdrB_i(regAdrB_i), .memAck_i(memAck_i), .stall_i(stall_i),
    .memReq_o(memReq_o), .memRW_o(memRW_o), .adrSel_o(adrSel_o), .pcWr_o(pcWr_o),
    .irWr_o(irWr_o), .regWr_o(regWr_o), .tempWr_o(tempWr_o), .flagsWr_o(flagsWr_o),
    .pcSel_o(pcSel_o), .regWrSel_o(regWrSel_o), .regWrAdr_o(regWrAdr_o),
    .fault_o(fault_o), .faultCode_o(faultCode_o), .state_o(state_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  // From FETCH, ack on the first FETCH_WAIT cycle; returns sitting in DECODE
  task automatic to_decode(input string t);
    memAck_i = 0; stall_i = 0; #1;
    chk({t, ".f.st"}, state_o, 0);
    chk({t, ".f.req"}, memReq_o, 1);
    tick;
    memAck_i = 1; #1;
    chk({t, ".fw.st"}, state_o, 1);
    chk({t, ".fw.ir"}, irWr_o, 1);
    tick;
    memAck_i = 0; #1;
    chk({t, ".dec.st"}, state_o, 2);
  endtask

  initial begin
    rst_i = 1; instOp_i = 0; branchRes_i = 0; regAdrA_i = 3'd3; regAdrB_i = 3'd6;
    memAck_i = 0; stall_i = 0;
    tick; tick;
    rst_i = 0; #1;
    chk("rst.st", state_o, 0);
    chk("rst.req", memReq_o, 1);
    chk("rst.pcwr", pcWr_o, 1);
    chk("rst.pcsel", pcSel_o, 0);
    chk("rst.rw", memRW_o, 0);
    chk("rst.fault", fault_o, 0);
    chk("rst.fcode", faultCode_o, 0);
    chk("rst.regwr", regWr_o, 0);

    // ALU; changing instOp_i in EXEC must not matter (latched class)
    to_decode("alu");
    instOp_i = 4'd2; tick;
    instOp_i = 4'd9; #1;
    chk("alu.ex.st", state_o, 3);
    chk("alu.ex.regwr", regWr_o, 1);
    chk("alu.ex.flags", flagsWr_o, 1);
    chk("alu.ex.wsel", regWrSel_o, 0);
    chk("alu.ex.wadr", regWrAdr_o, 3);
    chk("alu.ex.req", memReq_o, 0);
    tick;
    chk("alu.back.st", state_o, 0);

    // LOAD, ack on 3rd wait cycle
    to_decode("ld");
    instOp_i = 4'd3; tick;
    instOp_i = 4'd2; #1;
    chk("ld.ex.st", state_o, 3);
    chk("ld.ex.req", memReq_o, 1);
    chk("ld.ex.asel", adrSel_o, 2);
    chk("ld.ex.rw", memRW_o, 0);
    tick;
    chk("ld.mw1.st", state_o, 4);
    chk("ld.mw1.req", memReq_o, 1);
    chk("ld.mw1.asel", adrSel_o, 2);
    tick;
    chk("ld.mw2.st", state_o, 4);
    tick;
    memAck_i = 1; #1;
    chk("ld.mw3.st", state_o, 4);
    tick;
    memAck_i = 0; #1;
    chk("ld.wb.st", state_o, 5);
    chk("ld.wb.regwr", regWr_o, 1);
    chk("ld.wb.wsel", regWrSel_o, 2);
    chk("ld.wb.wadr", regWrAdr_o, 6);
    tick;
    chk("ld.back.st", state_o, 0);

    // STORE
    to_decode("st");
    instOp_i = 4'd4; tick;
    chk("st.ex.rw", memRW_o, 1);
    tick;
    memAck_i = 1; #1;
    chk("st.mw.st", state_o, 4);
    chk("st.mw.rw", memRW_o, 1);
    tick;
    memAck_i = 0; #1;
    chk("st.back.st", state_o, 0);
    chk("st.back.regwr", regWr_o, 0);

    // IMM
    to_decode("imm");
    instOp_i = 4'd5; tick;
    chk("imm.ex.regwr", regWr_o, 1);
    chk("imm.ex.wsel", regWrSel_o, 3);
    tick;

    // SWAP
    to_decode("swp");
    instOp_i = 4'd6; tick;
    chk("swp.ex.temp", tempWr_o, 1);
    chk("swp.ex.regwr", regWr_o, 1);
    chk("swp.ex.wadr", regWrAdr_o, 3);
    tick;
    chk("swp.s2.st", state_o, 6);
    chk("swp.s2.wsel", regWrSel_o, 4);
    chk("swp.s2.wadr", regWrAdr_o, 6);
    tick;
    chk("swp.back.st", state_o, 0);

    // LINK branch
    to_decode("lnk");
    instOp_i = 4'd1; tick;
    chk("lnk.pcwr", pcWr_o, 1);
    chk("lnk.pcsel", pcSel_o, 1);
    chk("lnk.wsel", regWrSel_o, 1);
    chk("lnk.wadr", regWrAdr_o, 5);
    tick;

    // Conditional branch, not taken then taken
    to_decode("bnt");
    instOp_i = 4'd0; branchRes_i = 0; tick;
    chk("bnt.pcwr", pcWr_o, 0);
    chk("bnt.pcsel", pcSel_o, 1);
    tick;
    to_decode("bt");
    instOp_i = 4'd0; branchRes_i = 1; tick;
    chk("bt.pcwr", pcWr_o, 1);
    tick;
    branchRes_i = 0;

    // Illegal op with stall; stray ack in DECODE is ignored
    to_decode("ill");
    instOp_i = 4'd9; stall_i = 1; memAck_i = 1; tick;
    chk("ill.stall.st", state_o, 2);
    tick;
    chk("ill.stall2.st", state_o, 2);
    stall_i = 0; memAck_i = 0; tick;
    chk("ill.flt.st", state_o, 7);
    chk("ill.flt.pulse", fault_o, 1);
    chk("ill.flt.code", faultCode_o, 1);
    chk("ill.flt.wadr", regWrAdr_o, 5);
    chk("ill.flt.pcsel", pcSel_o, 2);
    chk("ill.flt.pcwr", pcWr_o, 1);
    chk("ill.flt.wsel", regWrSel_o, 1);
    tick;
    chk("ill.back.st", state_o, 0);
    chk("ill.back.pulse", fault_o, 0);
    chk("ill.back.code", faultCode_o, 0);

    // Reset in MEM_WAIT abandons the transfer
    to_decode("rmw");
    instOp_i = 4'd3; tick; tick;
    chk("rmw.mw.st", state_o, 4);
    rst_i = 1; tick;
    rst_i = 0; #1;
    chk("rmw.st", state_o, 0);
    chk("rmw.asel", adrSel_o, 0);
    chk("rmw.req", memReq_o, 1);

`ifdef XM_BUS_TIMEOUT_EN
    // No ack: fault after TMO wait cycles
    to_decode("tmo");
    instOp_i = 4'd4; tick; tick;
    for (int i = 0; i < TMO; i++) begin
      chk($sformatf("tmo.mw%0d.st", i + 1), state_o, 4);
      tick;
    end
    chk("tmo.flt.st", state_o, 7);
    chk("tmo.flt.code", faultCode_o, 2);
    chk("tmo.flt.pulse", fault_o, 1);
    tick;
    // Ack on the last allowed cycle wins
    to_decode("tak");
    instOp_i = 4'd4; tick; tick;
    for (int i = 0; i < TMO - 1; i++) tick;
    memAck_i = 1; #1;
    chk("tak.mw4.st", state_o, 4);
    tick;
    memAck_i = 0; #1;
    chk("tak.back.st", state_o, 0);
    chk("tak.back.pulse", fault_o, 0);
    // Fetch wait timeout
    tick;
    for (int i = 0; i < TMO; i++) tick;
    chk("ftmo.st", state_o, 7);
    chk("ftmo.code", faultCode_o, 2);
    tick;
`else
    // Without the timeout the wait is indefinite
    to_decode("inf");
    instOp_i = 4'd4; tick; tick;
    for (int i = 0; i < 20; i++) tick;
    chk("inf.mw.st", state_o, 4);
    chk("inf.mw.pulse", fault_o, 0);
    memAck_i = 1; tick;
    memAck_i = 0; #1;
    chk("inf.back.st", state_o, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
